// File: rtl/model_write_vector_stream_if.sv
// Bus bundle for the buffered DNC write-vector stream: run control,
// upstream element input and downstream tagged element output.
//
// Handshake semantics (both sides are enable/stall pairs):
//   An input element transfers on a rising edge where V_IN_ENABLE=1 and
//   V_IN_STALL=0; while V_IN_STALL=1 the producer must hold V_IN and any
//   asserted V_IN_ENABLE is ignored. An output element is presented for
//   exactly the one cycle V_OUT_ENABLE=1; V_OUT_STALL=1 at an edge only
//   blocks the pop at that edge and never withdraws a presented element.
interface model_write_vector_stream_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
);
  logic                    START;
  logic                    READY;
  logic [DATA_SIZE-1:0]    SIZE_W_IN;
  logic [DATA_SIZE-1:0]    V_IN;
  logic                    V_IN_ENABLE;
  logic                    V_IN_STALL;
  logic [DATA_SIZE-1:0]    V_OUT;
  logic                    V_OUT_ENABLE;
  logic                    V_OUT_STALL;
  logic [CONTROL_SIZE-1:0] V_OUT_I;
  logic [CONTROL_SIZE-1:0] V_OUT_K;
  logic [1:0]              STATE_DBG;

  // Producer / consumer side (the environment around the stage)
  modport master (
    output START, SIZE_W_IN, V_IN, V_IN_ENABLE, V_OUT_STALL,
    input  READY, V_IN_STALL, V_OUT, V_OUT_ENABLE, V_OUT_I, V_OUT_K, STATE_DBG
  );

  // The stream stage itself
  modport slave (
    input  START, SIZE_W_IN, V_IN, V_IN_ENABLE, V_OUT_STALL,
    output READY, V_IN_STALL, V_OUT, V_OUT_ENABLE, V_OUT_I, V_OUT_K, STATE_DBG
  );
endinterface

// File: rtl/model_write_vector_stream.sv
// Buffered write-vector stream for HEADS write heads of SIZE_W_IN elements.
// Input elements are counted by (head, element), pushed into a small FIFO,
// and popped to a registered output tagged with their own (head, element).
// The output side runs independently of the control FSM.
module model_write_vector_stream #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int HEADS        = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input logic                     CLK,
  input logic                     RST,
  model_write_vector_stream_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CONTROL_SIZE-1:0] HEADS_M1 = CONTROL_SIZE'(HEADS - 1);
  localparam logic [AW:0]             FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [1:0]              state;
  logic                    ready_q;
  logic [CONTROL_SIZE-1:0] size_w;
  logic [CONTROL_SIZE-1:0] size_m1;
  logic [CONTROL_SIZE-1:0] in_i, in_k;
  logic [CONTROL_SIZE-1:0] out_i, out_k;

  logic [DATA_SIZE-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;

  logic [DATA_SIZE-1:0]    v_out_q;
  logic                    v_out_en_q;
  logic [CONTROL_SIZE-1:0] v_out_i_q, v_out_k_q;

  logic                    in_stall;
  logic                    push, pop, start_accept;
  logic                    in_last_k, out_last_k;

  // Last-element compare value, taken at control width
  assign size_m1    = size_w - CONTROL_SIZE'(1);
  assign in_last_k  = (in_k == size_m1);
  assign out_last_k = (out_k == size_m1);

  // Stall from registered state/count only, so a push can never hit a full FIFO
  assign in_stall     = RST || (state != ST_RUN) || (count == FULL_CNT);
  assign push         = bus.V_IN_ENABLE && !in_stall;
  assign pop          = (count != '0) && !bus.V_OUT_STALL;
  assign start_accept = (state == ST_IDLE) && bus.START;

  // Control FSM: run latch, input counters, completion pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
      size_w  <= '0;
      in_i    <= '0;
      in_k    <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            size_w <= CONTROL_SIZE'(bus.SIZE_W_IN);
            in_i   <= '0;
            in_k   <= '0;
            if (bus.SIZE_W_IN == '0) ready_q <= 1'b1;
            else                     state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (push) begin
            if (in_last_k) begin
              in_k <= '0;
              in_i <= in_i + CONTROL_SIZE'(1);
              if (in_i == HEADS_M1) state <= ST_DRAIN;
            end else begin
              in_k <= in_k + CONTROL_SIZE'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Every element is in the FIFO by now, so empty means all were output
          if (count == '0) begin
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.V_IN;
  end

  // Output register and output counters, independent of the FSM state
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_out_q    <= '0;
      v_out_en_q <= 1'b0;
      v_out_i_q  <= '0;
      v_out_k_q  <= '0;
      out_i      <= '0;
      out_k      <= '0;
    end else begin
      v_out_en_q <= pop;
      if (pop) begin
        v_out_q   <= mem[rd_ptr];
        v_out_i_q <= out_i;
        v_out_k_q <= out_k;
        if (out_last_k) begin
          out_k <= '0;
          out_i <= out_i + CONTROL_SIZE'(1);
        end else begin
          out_k <= out_k + CONTROL_SIZE'(1);
        end
      end else if (start_accept) begin
        // FIFO is always empty in IDLE, so this never competes with a pop
        out_i <= '0;
        out_k <= '0;
      end
    end
  end

  assign bus.V_IN_STALL   = in_stall;
  assign bus.READY        = ready_q;
  assign bus.V_OUT        = v_out_q;
  assign bus.V_OUT_ENABLE = v_out_en_q;
  assign bus.V_OUT_I      = v_out_i_q;
  assign bus.V_OUT_K      = v_out_k_q;
  assign bus.STATE_DBG    = state;

endmodule

// File: tb/tb_model_write_vector_stream.sv
// Self-checking bench for model_write_vector_stream (HEADS=2, FIFO_DEPTH=8).
module tb_model_write_vector_stream;

  localparam int DS    = 64;
  localparam int CS    = 64;
  localparam int HEADS = 2;
  localparam int DEPTH = 8;
  localparam int W     = DS + 2 * CS;

  logic CLK;
  logic RST;

  model_write_vector_stream_if #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) bus ();

  model_write_vector_stream #(
    .DATA_SIZE(DS), .CONTROL_SIZE(CS), .HEADS(HEADS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_cnt = 0;
  int ready_cnt = 0;
  int ready_cyc = -1;
  int first_out_cyc = -1;
  int last_out_cyc = -1;
  int first_acc_cyc = -1;

  // bench model of the input-side indices
  longint m_size = 0;
  longint m_i = 0;
  longint m_k = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge CLK) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    #1;
    cyc++;
    if (bus.V_OUT_ENABLE === 1'b1) begin
      got = {bus.V_OUT, bus.V_OUT_I, bus.V_OUT_K};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vout_unexpected got %0h expected none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL vout got %0h expected %0h", got, exp);
        end
      end
      out_cnt++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end
    if (bus.READY === 1'b1) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic start_run(input logic [DS-1:0] w);
    bus.START     = 1'b1;
    bus.SIZE_W_IN = w;
    m_size = longint'(w);
    m_i = 0;
    m_k = 0;
    first_out_cyc = -1;
    first_acc_cyc = -1;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  task automatic send(input logic [DS-1:0] d);
    int tries;
    tries = 0;
    bus.V_IN        = d;
    bus.V_IN_ENABLE = 1'b1;
    #1;
    while (bus.V_IN_STALL && tries < 300) begin
      @(negedge CLK);
      #1;
      tries++;
    end
    if (bus.V_IN_STALL) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got stall expected accept of %0h", d);
    end else begin
      exp_q.push_back({d, 64'(m_i), 64'(m_k)});
      if (first_acc_cyc < 0) first_acc_cyc = cyc + 1;
      if (m_k == m_size - 1) begin
        m_k = 0;
        m_i++;
      end else begin
        m_k++;
      end
    end
    @(negedge CLK);
    bus.V_IN_ENABLE = 1'b0;
  endtask

  task automatic wait_ready(input int target, input string name);
    int t;
    t = 0;
    while (ready_cnt < target && t < 300) begin
      @(negedge CLK);
      t++;
    end
    check(name, 64'(ready_cnt), 64'(target));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    int s_cyc;
    RST             = 1'b1;
    bus.START       = 1'b0;
    bus.SIZE_W_IN   = '0;
    bus.V_IN        = '0;
    bus.V_IN_ENABLE = 1'b0;
    bus.V_OUT_STALL = 1'b0;
    repeat (3) @(negedge CLK);

    // reset state
    check("rst_ready", 64'(bus.READY), 64'(0));
    check("rst_ena", 64'(bus.V_OUT_ENABLE), 64'(0));
    check("rst_vout", bus.V_OUT, 64'(0));
    check("rst_i", bus.V_OUT_I, 64'(0));
    check("rst_k", bus.V_OUT_K, 64'(0));
    check("rst_stall", 64'(bus.V_IN_STALL), 64'(1));
    RST = 1'b0;
    @(negedge CLK);
    check("idle_stall", 64'(bus.V_IN_STALL), 64'(1));

    // basic run: 2 heads x 3 elements, back to back
    start_run(3);
    for (int j = 1; j <= 6; j++) send(DS'(j));
    check("basic_drain_stall", 64'(bus.V_IN_STALL), 64'(1));
    wait_ready(1, "basic_ready");
    check("basic_latency", 64'(first_out_cyc), 64'(first_acc_cyc + 1));
    check("basic_consecutive", 64'(last_out_cyc - first_out_cyc), 64'(5));
    check("basic_ready_cyc", 64'(ready_cyc), 64'(last_out_cyc + 1));
    repeat (2) @(negedge CLK);
    check("basic_ready_once", 64'(ready_cnt), 64'(1));
    check("basic_out_cnt", 64'(out_cnt), 64'(6));

    // backpressure: 2 heads x 5 elements into an 8-deep FIFO
    base = out_cnt;
    bus.V_OUT_STALL = 1'b1;
    start_run(5);
    for (int j = 1; j <= 7; j++) send(DS'(64'h100 + j));
    check("bp_not_full", 64'(bus.V_IN_STALL), 64'(0));
    send(DS'(64'h108));
    check("bp_full_stall", 64'(bus.V_IN_STALL), 64'(1));
    bus.V_IN        = DS'(64'h109);
    bus.V_IN_ENABLE = 1'b1;
    repeat (3) @(negedge CLK);
    check("bp_still_stall", 64'(bus.V_IN_STALL), 64'(1));
    check("bp_no_output", 64'(out_cnt - base), 64'(0));
    bus.V_OUT_STALL = 1'b0;
    send(DS'(64'h109));
    send(DS'(64'h10a));
    wait_ready(2, "bp_ready");
    check("bp_out_cnt", 64'(out_cnt - base), 64'(10));

    // zero size
    base = out_cnt;
    s_cyc = cyc + 1;
    start_run(0);
    check("zero_ready", 64'(ready_cnt), 64'(3));
    check("zero_ready_cyc", 64'(ready_cyc), 64'(s_cyc));
    repeat (3) @(negedge CLK);
    check("zero_stall", 64'(bus.V_IN_STALL), 64'(1));
    check("zero_no_output", 64'(out_cnt - base), 64'(0));

    // protocol corners: input in IDLE, START during RUN
    bus.V_IN        = DS'(64'hdead);
    bus.V_IN_ENABLE = 1'b1;
    repeat (3) @(negedge CLK);
    check("idle_input_stall", 64'(bus.V_IN_STALL), 64'(1));
    bus.V_IN_ENABLE = 1'b0;
    base = out_cnt;
    start_run(3);
    send(DS'(64'h21));
    bus.START     = 1'b1;
    bus.SIZE_W_IN = DS'(7);
    send(DS'(64'h22));
    send(DS'(64'h23));
    bus.START = 1'b0;
    for (int j = 4; j <= 6; j++) send(DS'(64'h20 + j));
    wait_ready(4, "corner_ready");
    check("corner_out_cnt", 64'(out_cnt - base), 64'(6));

    // reset mid-run after 3 of 6 accepted
    base = out_cnt;
    start_run(3);
    for (int j = 1; j <= 3; j++) send(DS'(64'h30 + j));
    RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    check("mid_rst_ena", 64'(bus.V_OUT_ENABLE), 64'(0));
    check("mid_rst_vout", bus.V_OUT, 64'(0));
    check("mid_rst_i", bus.V_OUT_I, 64'(0));
    check("mid_rst_k", bus.V_OUT_K, 64'(0));
    check("mid_rst_ready", 64'(bus.READY), 64'(0));
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("mid_rst_no_ready", 64'(ready_cnt), 64'(4));
    check("mid_rst_out_cnt", 64'(out_cnt - base), 64'(2));
    start_run(3);
    for (int j = 1; j <= 6; j++) send(DS'(64'h40 + j));
    wait_ready(5, "fresh_ready");

    // back-to-back runs with START held through READY
    bus.START     = 1'b1;
    bus.SIZE_W_IN = DS'(2);
    m_size = 2;
    m_i = 0;
    m_k = 0;
    @(negedge CLK);
    for (int j = 1; j <= 4; j++) send(DS'(64'h50 + j));
    bus.SIZE_W_IN = DS'(3);
    wait_ready(6, "b2b_ready1");
    check("b2b_idle_stall", 64'(bus.V_IN_STALL), 64'(1));
    m_size = 3;
    m_i = 0;
    m_k = 0;
    @(negedge CLK);
    check("b2b_restart", 64'(bus.V_IN_STALL), 64'(0));
    bus.START = 1'b0;
    for (int j = 1; j <= 6; j++) send(DS'(64'h60 + j));
    wait_ready(7, "b2b_ready2");

    repeat (3) @(negedge CLK);
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
